otp_key_scheduler: RTL and testbench

Controller that sequences the 8-bit XOR cipher datapath as a one-time pad and shares it between two requesters. It holds the secret key in flip-flops, advances it through a Galois LFSR after every use so no pad byte is ever reused, zeroizes the key after a fixed number of uses, and returns each ciphertext with the ID of the requester that sent it. It sits between the plaintext producers and the ciphertext consumer.

---
 rtl/otp_pkg.sv | 21 ++
 rtl/otp_key_scheduler_if.sv | 28 ++
 rtl/otp_rr_arb.sv | 29 ++
 rtl/otp_key_scheduler.sv | 159 +++++++++++++++
 tb/tb_otp_key_scheduler.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/otp_pkg.sv
// otp_pkg: shared width default, controller state encoding and LFSR step
// for the one-time-pad key scheduler.
package otp_pkg;

  localparam int unsigned OTP_DATA_W = 8;

  typedef enum logic [1:0] {
    NOKEY,
    IDLE,
    HOLD
  } otp_state_t;

  // One Galois LFSR step: shift right, fold in taps when the dropped bit is 1.
  function automatic logic [OTP_DATA_W-1:0] lfsr_step(
    input logic [OTP_DATA_W-1:0] k,
    input logic [OTP_DATA_W-1:0] taps
  );
    return (k >> 1) ^ (k[0] ? taps : '0);
  endfunction

endpackage

// File: rtl/otp_key_scheduler_if.sv
// otp_key_scheduler_if: two plaintext requester handshakes plus the
// ciphertext response handshake. slave = scheduler side, master = clients.
interface otp_key_scheduler_if
  import otp_pkg::*;
#(
  parameter int unsigned DATA_W = OTP_DATA_W
);
  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_id;
  logic              rsp_ready;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/otp_rr_arb.sv
// otp_rr_arb: two-input round-robin arbiter. The grant is combinational
// from the request vector; the pointer (last granted index) moves only
// when the caller reports an accept.
module otp_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_gnt
);
  logic r_last;

  // On contention grant the requester that did not win last time.
  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) begin
      o_gnt = r_last ? 2'b01 : 2'b10;
    end
  end

  // Pointer starts at 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (i_accept) begin
      r_last <= o_gnt[1];
    end
  end
endmodule

// File: rtl/otp_key_scheduler.sv
// otp_key_scheduler: sequences an XOR one-time pad shared by two requesters.
// The key advances through a Galois LFSR after every use and is zeroized
// after MAX_USES uses. Optional build macro OTP_MASK_EN stores the key as
// two boolean shares refreshed with rnd_in; port-visible behaviour is the same.
module otp_key_scheduler
  import otp_pkg::*;
#(
  parameter int unsigned       DATA_W    = OTP_DATA_W,
  parameter logic [DATA_W-1:0] LFSR_TAPS = 8'hB8,
  parameter int unsigned       MAX_USES  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              key_load,
  input  logic [DATA_W-1:0] key_in,
`ifdef OTP_MASK_EN
  input  logic [DATA_W-1:0] rnd_in,
`endif
  output logic              key_valid,
  output logic [7:0]        uses_left,
  otp_key_scheduler_if.slave bus
);
  localparam logic [7:0] USES_INIT = 8'(MAX_USES);

  otp_state_t        r_state;
  otp_state_t        w_next;
  logic [1:0]        w_gnt;
  logic              w_arb_en;
  logic              w_accept;
  logic              w_load;
  logic              w_rsp_done;
  logic              w_zeroize;
  logic [DATA_W-1:0] w_sel_data;
  logic [DATA_W-1:0] w_ct;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_id;
  logic [7:0]        r_uses;

  otp_rr_arb u_arb (
    .clk      (clk),
    .rst_n    (reset_n),
    .i_req    ({bus.req1_valid, bus.req0_valid}),
    .i_accept (w_accept),
    .o_gnt    (w_gnt)
  );

  assign w_accept   = w_arb_en & (|w_gnt);
  assign w_load     = key_load & (key_in != '0) & ((r_state == NOKEY) | (r_state == IDLE));
  assign w_rsp_done = (r_state == HOLD) & bus.rsp_ready;
  assign w_zeroize  = w_rsp_done & (r_uses == '0);
  assign w_sel_data = w_gnt[1] ? bus.req1_data : bus.req0_data;

  assign bus.req0_ready = w_gnt[0] & w_arb_en;
  assign bus.req1_ready = w_gnt[1] & w_arb_en;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.rsp_id     = r_rsp_id;
  assign uses_left      = r_uses;

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= NOKEY;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state: load -> serve one byte -> wait for consumer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      NOKEY:   if (w_load) w_next = IDLE;
      IDLE:    if (w_accept) w_next = HOLD;
      HOLD:    if (w_rsp_done) w_next = (r_uses != '0) ? IDLE : NOKEY;
      default: w_next = NOKEY;
    endcase
  end

  // FSM outputs: a key_load in IDLE blocks arbitration for that cycle.
  always_comb begin
    key_valid = 1'b0;
    w_arb_en  = 1'b0;
    case (r_state)
      IDLE: begin
        key_valid = 1'b1;
        w_arb_en  = ~key_load;
      end
      HOLD:    key_valid = 1'b1;
      default: ;
    endcase
  end

`ifdef OTP_MASK_EN
  logic [DATA_W-1:0] r_sh0;
  logic [DATA_W-1:0] r_sh1;

  // sh0 is folded in first so the unmasked key never exists as a wire.
  assign w_ct = (w_sel_data ^ r_sh0) ^ r_sh1;

  // Share update: the LFSR step is linear, so stepping each share and
  // adding the same fresh mask to both keeps sh0 ^ sh1 equal to the key.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sh0 <= '0;
      r_sh1 <= '0;
    end else if (w_load) begin
      r_sh0 <= key_in ^ rnd_in;
      r_sh1 <= rnd_in;
    end else if (w_accept) begin
      r_sh0 <= lfsr_step(r_sh0, LFSR_TAPS) ^ rnd_in;
      r_sh1 <= lfsr_step(r_sh1, LFSR_TAPS) ^ rnd_in;
    end else if (w_zeroize) begin
      r_sh0 <= '0;
      r_sh1 <= '0;
    end
  end
`else
  logic [DATA_W-1:0] r_key;

  assign w_ct = w_sel_data ^ r_key;

  // Key register: seed, advance per use, clear on exhaustion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_key <= '0;
    end else if (w_load) begin
      r_key <= key_in;
    end else if (w_accept) begin
      r_key <= lfsr_step(r_key, LFSR_TAPS);
    end else if (w_zeroize) begin
      r_key <= '0;
    end
  end
`endif

  // Response register and use counter; rsp_data is kept after handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= 1'b0;
      r_uses      <= '0;
    end else begin
      if (w_load) begin
        r_uses <= USES_INIT;
      end else if (w_accept) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= w_ct;
        r_rsp_id    <= w_gnt[1];
        r_uses      <= r_uses - 8'd1;
      end
      if (w_rsp_done) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_otp_key_scheduler.sv
// tb_otp_key_scheduler: directed scoreboard bench for otp_key_scheduler
// (MAX_USES = 2). Stimulus pushes expected {id, ciphertext}; a monitor pops
// and compares on each response handshake.
module tb_otp_key_scheduler;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       key_load = 1'b0;
  logic [7:0] key_in = '0;
  logic       key_valid;
  logic [7:0] uses_left;
`ifdef OTP_MASK_EN
  logic [7:0] rnd_in = '0;
`endif

  otp_key_scheduler_if #(.DATA_W(8)) bus ();

  otp_key_scheduler #(
    .DATA_W    (8),
    .LFSR_TAPS (8'hB8),
    .MAX_USES  (2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .key_load  (key_load),
    .key_in    (key_in),
`ifdef OTP_MASK_EN
    .rnd_in    (rnd_in),
`endif
    .key_valid (key_valid),
    .uses_left (uses_left),
    .bus       (bus)
  );

  always #5 clk = ~clk;

`ifdef OTP_MASK_EN
  initial forever begin
    @(negedge clk);
    rnd_in = 8'($urandom);
  end
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0] m_key = '0;
  logic [7:0] m_uses = '0;
  logic       m_last = 1'b1;
  logic [8:0] m_exp = '0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;

  function automatic logic [7:0] m_lfsr(input logic [7:0] k);
    return (k >> 1) ^ (k[0] ? 8'hB8 : 8'h00);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for any pending response to be consumed (rsp_ready must be high).
  task automatic drain();
    for (int i = 0; i < 20 && bus.rsp_valid; i++) tick();
    chk("drain", bus.rsp_valid, 0);
  endtask

  task automatic load_key(input logic [7:0] k);
    drain();
    key_load = 1'b1;
    key_in   = k;
    tick();
    key_load = 1'b0;
    key_in   = '0;
    if (k != 8'h00) begin
      m_key  = k;
      m_uses = 8'd2;
    end
    chk("key_valid_after_load", key_valid, 1);
    chk("uses_after_load", uses_left, m_uses);
  endtask

  // Wait for n accepts with the current request pattern; predict each one.
  task automatic serve(input int n);
    int         got = 0;
    logic [1:0] eg;
    logic [7:0] d;
    for (int cyc = 0; cyc < 40 && got < n; cyc++) begin
      #1;
      if (bus.req0_ready || bus.req1_ready) begin
        if (bus.req0_valid && bus.req1_valid) eg = m_last ? 2'b01 : 2'b10;
        else eg = {bus.req1_valid, bus.req0_valid};
        chk("grant", {bus.req1_ready, bus.req0_ready}, eg);
        d      = eg[1] ? bus.req1_data : bus.req0_data;
        m_exp  = {eg[1], d ^ m_key};
        exp_q.push_back(m_exp);
        m_key  = m_lfsr(m_key);
        m_uses = m_uses - 8'd1;
        m_last = eg[1];
        got++;
      end
      tick();
    end
    if (got < n) begin
      errors++;
      checks++;
      $display("FAIL serve_timeout: got %0d accepts expected %0d", got, n);
    end
  endtask

  // Scoreboard monitor: one pop per response handshake.
  always @(negedge clk) begin
    if (reset_n && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got id=%0d data=0x%0h expected none", bus.rsp_id, bus.rsp_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_id", bus.rsp_id, mon_e[8]);
        chk("rsp_data", bus.rsp_data, mon_e[7:0]);
      end
    end
  end

  initial begin
    bus.req0_valid = 1'b0;
    bus.req0_data  = '0;
    bus.req1_valid = 1'b0;
    bus.req1_data  = '0;
    bus.rsp_ready  = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    bus.req0_valid = 1'b1;
    #2;
    chk("rst_key_valid", key_valid, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_uses", uses_left, 0);
    chk("rst_ready0", bus.req0_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    bus.req0_valid = 1'b0;

    // Zero seed ignored in NOKEY
    key_load = 1'b1;
    key_in   = 8'h00;
    tick();
    key_load = 1'b0;
    chk("zero_seed_key_valid", key_valid, 0);
    chk("zero_seed_uses", uses_left, 0);

    // Basic encrypt: 0x3C ^ 0x5A = 0x66, then 0x00 ^ 0x2D = 0x2D
    load_key(8'h5A);
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'h3C;
    serve(1);
    chk("basic_ct0", bus.rsp_data, 8'h66);
    bus.req0_data = 8'h00;
    serve(1);
    chk("basic_ct1", bus.rsp_data, 8'h2D);
    chk("basic_id", bus.rsp_id, 0);

    // Exhaustion: key zeroized, requests blocked until reload
    drain();
    chk("exh_key_valid", key_valid, 0);
    chk("exh_uses", uses_left, 0);
    for (int i = 0; i < 2; i++) begin
      chk("exh_ready0", bus.req0_ready, 0);
      tick();
    end
    load_key(8'h11);
    serve(1);
    chk("reload_ct", bus.rsp_data, 8'h11);

    // key_load beats a simultaneous request
    drain();
    key_load = 1'b1;
    key_in   = 8'h77;
    #1;
    chk("prio_ready0", bus.req0_ready, 0);
    tick();
    key_load = 1'b0;
    key_in   = '0;
    m_key    = 8'h77;
    m_uses   = 8'd2;
    serve(1);
    chk("prio_ct", bus.rsp_data, 8'h77);
    bus.req0_valid = 1'b0;

    // Arbitration: both valid, grants alternate across two key loads
    load_key(8'hC3);
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'hA5;
    bus.req1_valid = 1'b1;
    bus.req1_data  = 8'h5A;
    serve(2);
    load_key(8'h9E);
    serve(2);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // Backpressure: response held stable, no further accepts
    load_key(8'h3B);
    bus.rsp_ready  = 1'b0;
    bus.req1_valid = 1'b1;
    bus.req1_data  = 8'h0F;
    serve(1);
    bus.req0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_rsp_valid", bus.rsp_valid, 1);
      chk("bp_rsp_data", bus.rsp_data, m_exp[7:0]);
      chk("bp_rsp_id", bus.rsp_id, m_exp[8]);
      chk("bp_readies", {bus.req1_ready, bus.req0_ready}, 0);
      chk("bp_uses", uses_left, 1);
      tick();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'h00;
    serve(1);
    bus.req0_valid = 1'b0;

    // Reset while a response is pending
    load_key(8'h5A);
    bus.rsp_ready  = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'h3C;
    serve(1);
    bus.req0_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rstmid_rsp_valid", bus.rsp_valid, 0);
    chk("rstmid_key_valid", key_valid, 0);
    chk("rstmid_uses", uses_left, 0);
    exp_q.delete();
    m_key  = '0;
    m_uses = '0;
    m_last = 1'b1;
    @(negedge clk);
    reset_n       = 1'b1;
    bus.rsp_ready = 1'b1;
    tick();

    // Basic encrypt again; pointer reset means req0 wins contention
    load_key(8'h5A);
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'h3C;
    bus.req1_valid = 1'b1;
    bus.req1_data  = 8'hFF;
    serve(1);
    chk("post_rst_ct", bus.rsp_data, 8'h66);
    chk("post_rst_id", bus.rsp_id, 0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    drain();
    repeat (3) tick();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
